// File: rtl/dsu_seq_pkg.sv
// Shared types for the DSU layer sequencer: FSM states, layer descriptor and mode encodings.
package dsu_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLaunch,
    StRun,
    StDrain,
    StFinish
  } seq_state_t;

  typedef struct packed {
    logic mode;
    logic fb;
  } layer_desc_t;

  localparam logic MODE_CONV = 1'b0;
  localparam logic MODE_MLP  = 1'b1;

endpackage

// File: rtl/dsu_layer_sequencer_if.sv
// Host/config and controller handshake bundle for the DSU layer sequencer.
interface dsu_layer_sequencer_if #(
  parameter int unsigned LIDX_W = 3
) ();

  logic              cfg_wr_en;
  logic [LIDX_W-1:0] cfg_wr_idx;
  logic              cfg_wr_mode;
  logic              cfg_wr_fb;
  logic              start;
  logic [LIDX_W:0]   num_layers;
  logic              abort;
  logic              conv_done;
  logic              fc_done;
  logic              mode;
  logic              omem_fb_en;
  logic              conv_start;
  logic              fc_start;
  logic              busy;
  logic [LIDX_W-1:0] cur_layer;
  logic              pass_done;
  logic              err;

  modport master (
    output cfg_wr_en, cfg_wr_idx, cfg_wr_mode, cfg_wr_fb, start, num_layers, abort,
    output conv_done, fc_done,
    input  mode, omem_fb_en, conv_start, fc_start, busy, cur_layer, pass_done, err
  );

  modport slave (
    input  cfg_wr_en, cfg_wr_idx, cfg_wr_mode, cfg_wr_fb, start, num_layers, abort,
    input  conv_done, fc_done,
    output mode, omem_fb_en, conv_start, fc_start, busy, cur_layer, pass_done, err
  );

endinterface

// File: rtl/layer_desc_table.sv
// Layer descriptor register file: one write port, one combinational read port.
module layer_desc_table
  import dsu_seq_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 8,
  parameter int unsigned LIDX_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [LIDX_W-1:0] wr_idx,
  input  layer_desc_t       wr_data,
  input  logic [LIDX_W-1:0] rd_idx,
  output layer_desc_t       rd_data
);

  layer_desc_t mem_q [NUM_LAYERS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_LAYERS); i++) mem_q[i] <= '0;
    end else if (wr_en && (32'(wr_idx) < NUM_LAYERS)) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (32'(rd_idx) < NUM_LAYERS) rd_data = mem_q[rd_idx];
  end

endmodule

// File: rtl/dsu_layer_sequencer.sv
// Steps the DSU through a multi-layer pass, inserting settle/drain cycles around each
// controller run so the DSU's delayed steering flags never straddle a layer boundary.
module dsu_layer_sequencer
  import dsu_seq_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 8,
  parameter int unsigned LIDX_W     = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  dsu_layer_sequencer_if.slave bus
);

  localparam logic [LIDX_W:0] MaxLayers = (LIDX_W + 1)'(NUM_LAYERS);

  seq_state_t        state_q, state_d;
  logic              mode_q, mode_d;
  logic              fb_q, fb_d;
  logic              busy_q, busy_d;
  logic [LIDX_W-1:0] cur_q, cur_d;
  logic [LIDX_W:0]   n_lat_q, n_lat_d;
  logic              err_q, err_d;
  // Set for a zero-layer pass so FINISH holds one extra cycle before pulsing.
  logic              empty_q, empty_d;

  logic              conv_start, fc_start, pass_done;
  logic              done_act, done_other;
  logic [LIDX_W:0]   next_idx;
  layer_desc_t       wr_desc, rd_desc;

  assign wr_desc = '{mode: bus.cfg_wr_mode, fb: bus.cfg_wr_fb};

  layer_desc_table #(
    .NUM_LAYERS (NUM_LAYERS),
    .LIDX_W     (LIDX_W)
  ) u_desc_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bus.cfg_wr_en && (state_q == StIdle)),
    .wr_idx  (bus.cfg_wr_idx),
    .wr_data (wr_desc),
    .rd_idx  (cur_q),
    .rd_data (rd_desc)
  );

  assign done_act   = (mode_q == MODE_CONV) ? bus.conv_done : bus.fc_done;
  assign done_other = (mode_q == MODE_CONV) ? bus.fc_done : bus.conv_done;
  assign next_idx   = {1'b0, cur_q} + (LIDX_W + 1)'(1);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    fb_d       = fb_q;
    cur_d      = cur_q;
    n_lat_d    = n_lat_q;
    err_d      = err_q;
    empty_d    = empty_q;
    conv_start = 1'b0;
    fc_start   = 1'b0;
    pass_done  = 1'b0;

    if (bus.abort && (state_q != StIdle)) begin
      state_d = StIdle;
      fb_d    = 1'b0;
      empty_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            n_lat_d = bus.num_layers;
            if (bus.num_layers > MaxLayers) begin
              err_d = 1'b1;
            end else begin
              err_d = 1'b0;
              cur_d = '0;
              if (bus.num_layers == '0) begin
                state_d = StFinish;
                empty_d = 1'b1;
              end else begin
                state_d = StSetup;
              end
            end
          end
        end
        StSetup: begin
          mode_d  = rd_desc.mode;
          fb_d    = rd_desc.fb;
          state_d = StLaunch;
        end
        StLaunch: begin
          conv_start = (mode_q == MODE_CONV);
          fc_start   = (mode_q == MODE_MLP);
          state_d    = StRun;
        end
        StRun: begin
          if (done_act) state_d = StDrain;
        end
        StDrain: begin
          if (next_idx < n_lat_q) begin
            cur_d   = next_idx[LIDX_W-1:0];
            state_d = StSetup;
          end else begin
            state_d = StFinish;
          end
        end
        StFinish: begin
          if (empty_q) begin
            empty_d = 1'b0;
          end else begin
            pass_done = 1'b1;
            state_d   = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Stray dones are flagged regardless of abort; LAUNCH deliberately ignores them.
    if ((state_q == StRun) && done_other) err_d = 1'b1;
    if (((state_q == StDrain) || (state_q == StSetup)) && (bus.conv_done || bus.fc_done)) begin
      err_d = 1'b1;
    end

    busy_d = (state_d == StSetup) || (state_d == StLaunch) ||
             (state_d == StRun) || (state_d == StDrain);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      fb_q    <= 1'b0;
      busy_q  <= 1'b0;
      cur_q   <= '0;
      n_lat_q <= '0;
      err_q   <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      fb_q    <= fb_d;
      busy_q  <= busy_d;
      cur_q   <= cur_d;
      n_lat_q <= n_lat_d;
      err_q   <= err_d;
      empty_q <= empty_d;
    end
  end

  assign bus.mode       = mode_q;
  assign bus.omem_fb_en = fb_q;
  assign bus.conv_start = conv_start;
  assign bus.fc_start   = fc_start;
  assign bus.busy       = busy_q;
  assign bus.cur_layer  = cur_q;
  assign bus.pass_done  = pass_done;
  assign bus.err        = err_q;

endmodule

// File: doc/dsu_layer_sequencer.md
# dsu_layer_sequencer

Sequences a multi-layer inference pass through the shared datapath. For each layer it drives the DSU's `mode` (Conv/MLP) and `omem_fb_en` (fib_memory vs output_memory feedback source), pulses the start of the matching controller, and waits for that controller's done. It inserts settle and drain cycles so the DSU's one-cycle-delayed steering flags never mis-route read data across a layer boundary. It sits between the host/config interface and the conv/FC controllers, one level above the DSU.

## Interface
Parameters:
- `NUM_LAYERS`, 8, depth of the layer descriptor table
- `LIDX_W`, 3, layer index width, equal to $clog2(NUM_LAYERS)

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `cfg_wr_en`  in  1  write one descriptor
- `cfg_wr_idx`  in  LIDX_W  descriptor index
- `cfg_wr_mode`  in  1  0 = Conv, 1 = MLP
- `cfg_wr_fb`  in  1  1 = layer reads its input from output_memory feedback
- `start`  in  1  begin a pass; sampled only in IDLE
- `num_layers`  in  LIDX_W+1  layer count for the pass, sampled with `start`
- `abort`  in  1  terminate the pass
- `conv_done`  in  1  conv controller finished (1-cycle pulse)
- `fc_done`  in  1  FC controller finished (1-cycle pulse)
- `mode`  out  1  to DSU `mode`
- `omem_fb_en`  out  1  to DSU `omem_fb_en`
- `conv_start`  out  1  1-cycle start pulse to the conv controller
- `fc_start`  out  1  1-cycle start pulse to the FC controller
- `busy`  out  1  high from SETUP through DRAIN of the last layer
- `cur_layer`  out  LIDX_W  index of the active layer
- `pass_done`  out  1  1-cycle pulse when the last layer completes
- `err`  out  1  sticky flag: unexpected done seen, or `num_layers` > NUM_LAYERS

## Operation
- Descriptor table: NUM_LAYERS entries of {mode, fb}.
  - Written only in IDLE.
  - `cfg_wr_en` outside IDLE is ignored.
- States: IDLE, SETUP, LAUNCH, RUN, DRAIN, FINISH.
- IDLE, `start`=1:
  - Latch `num_layers` into `n_lat`.
  - If `n_lat`=0: go to FINISH, no launches.
  - If `n_lat` > NUM_LAYERS: set `err`, stay IDLE, no `pass_done`.
  - Otherwise set `cur_layer`=0 and go to SETUP.
- SETUP: load `mode`/`omem_fb_en` from descriptor[`cur_layer`], then go to LAUNCH.
- LAUNCH:
  - Assert `conv_start` if `mode`=0, else `fc_start`. Exactly one pulse per layer.
  - Go to RUN.
- RUN:
  - Wait for the done of the active controller, then go to DRAIN.
  - A done from the non-active controller sets `err` and is otherwise ignored.
- DRAIN: one cycle, `mode`/`omem_fb_en` held.
  - If `cur_layer`+1 < `n_lat`: increment `cur_layer`, go to SETUP.
  - Otherwise go to FINISH.
- FINISH: pulse `pass_done`, go to IDLE.
  - `mode`/`omem_fb_en` keep the last layer's values until the next SETUP.
- `abort`:
  - In any non-IDLE state, go to IDLE next cycle.
  - Clear `omem_fb_en`, no `pass_done`, no start pulse that cycle.
  - `abort` has priority over done and over LAUNCH.
- `start` while not IDLE: ignored.
- `err`: cleared only by reset or by an accepted `start`.
- Reset values:
  - All outputs 0 (`mode`=0, `omem_fb_en`=0, no pulses, `busy`=0, `cur_layer`=0, `err`=0).
  - State IDLE, descriptor table all zeros.

## Timing
- `start` accepted at edge t:
  - SETUP at t+1.
  - `mode`/`omem_fb_en` valid at t+2.
  - Start pulse high during cycle t+2, i.e. one full settle cycle before launch.
- Done seen in cycle d:
  - DRAIN at d+1.
  - Next SETUP at d+2, new `mode`/`omem_fb_en` at d+3, next start pulse during d+3.
  - Layer-to-layer overhead is 3 cycles. This guarantees DSU `omem_fb_en_d` and `mlp_w2_sel_d` have retired the prior layer's last read.
- A done in the same cycle as the start pulse: not possible (RUN not yet entered); ignored in LAUNCH.
- A done pulse arriving in DRAIN or SETUP: sets `err`.
- `pass_done` asserts the cycle after the last DRAIN.
- `num_layers`=0: `pass_done` 2 cycles after `start`, `busy` stays 0.
- `busy` is registered and high in SETUP, LAUNCH, RUN and DRAIN.

## Structure
- Package `dsu_seq_pkg`:
  - `seq_state_t` enum.
  - `layer_desc_t` packed struct {mode, fb}.
  - Constants MODE_CONV=0, MODE_MLP=1.
- Sub-module `layer_desc_table`: NUM_LAYERS × `layer_desc_t` register file, one write port and one combinational read port, synchronous active-low reset to zero.
- FSM, layer counter and `err` logic stay in the top.

## Test plan
- Reset mid-RUN (rst_n=0 one cycle): all outputs 0, state IDLE, descriptor table zeroed; a following `start` with `num_layers`=1 launches `conv_start`.
- Table {0:conv/fb0, 1:conv/fb1, 2:mlp/fb1}, `num_layers`=3, dones after 5 cycles each:
  - Pulses in order conv, conv, fc.
  - `omem_fb_en` 0,1,1; `mode` 0,0,1.
  - Each start pulse comes 3 cycles after the previous done; `pass_done` 1 cycle after the last DRAIN.
- Layer 0 is MLP and `conv_done` is injected in RUN: `err`=1, still waits; `fc_done` then completes the pass normally.
- `num_layers`=0: no start pulses, `pass_done` at t+2, `busy`=0. `num_layers`=9 with NUM_LAYERS=8: `err`=1, no `pass_done`.
- `abort` in the same cycle as the done of layer 1 of 3: IDLE next cycle, `omem_fb_en`=0, no further starts, no `pass_done`.
- `cfg_wr_en` and `start` while busy: table unchanged (read back on next pass), current pass unaffected.
